instr_decode: RTL and testbench

Registered instruction decode stage. Accepts 32-bit instruction words (offset[31:19] | ra[18:14] | rb[13:9] | rd[8:4] | opcode[3:0]) over a valid/ready handshake and presents decoded register indices, a sign-extended immediate and control strobes to the execute stage one cycle later. A two-entry skid buffer gives full throughput under downstream back-pressure. The block sits between instruction fetch (or the debug instruction port) and the ALU/memory/branch datapath inside `top`.

---
 rtl/instr_decode.sv | 174 +++++++++++++++++
 tb/tb_instr_decode.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Registered instruction decode stage. Decodes 32-bit words
//               into register indices, sign-extended immediate and control
//               strobes; a main output register plus a skid register give
//               full throughput under downstream back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [4:0]           ra_o,
  output logic [4:0]           rb_o,
  output logic [4:0]           rd_o,
  output logic [DATAWIDTH-1:0] imm_o,
  output logic [2:0]           alu_op_o,
  output logic                 use_imm_o,
  output logic                 reg_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 branch_o,
  output logic [1:0]           br_cond_o,
  output logic                 illegal_o,
  output logic [7:0]           illegal_cnt_o
);

  localparam logic [3:0] c_op_addi = 4'd7;
  localparam logic [3:0] c_op_lw   = 4'd8;
  localparam logic [3:0] c_op_sw   = 4'd9;
  localparam logic [3:0] c_op_beq  = 4'd10;
  localparam logic [3:0] c_op_bgt  = 4'd11;
  localparam logic [3:0] c_op_bge  = 4'd12;
  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [7:0] c_cnt_max = 8'd255;

  typedef struct packed {
    logic [4:0]           ra;
    logic [4:0]           rb;
    logic [4:0]           rd;
    logic [DATAWIDTH-1:0] imm;
    logic [2:0]           alu_op;
    logic                 use_imm;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic [1:0]           br_cond;
    logic                 illegal;
  } bundle_t;

  bundle_t    w_dec;
  bundle_t    r_main;
  bundle_t    r_skid;
  logic       r_main_valid;
  logic       r_skid_valid;
  logic [7:0] r_illegal_cnt;
  logic       w_accept;
  logic       w_consume;
  logic [3:0] w_opcode;

  assign w_opcode  = instr_i[3:0];
  // A word can only be offered while skid is empty, so acceptance never
  // coincides with a skid-to-main transfer.
  assign w_accept  = in_valid_i & ~r_skid_valid;
  assign w_consume = r_main_valid & out_ready_i;

  // Decode the incoming word so both storage entries hold finished bundles
  always_comb begin
    w_dec           = '0;
    w_dec.ra        = instr_i[18:14];
    w_dec.rb        = instr_i[13:9];
    w_dec.rd        = instr_i[8:4];
    w_dec.imm       = {{(DATAWIDTH-13){instr_i[31]}}, instr_i[31:19]};
    if (w_opcode <= 4'd6) begin
      w_dec.alu_op    = w_opcode[2:0];
      w_dec.reg_write = 1'b1;
    end else begin
      case (w_opcode)
        c_op_addi: begin
          w_dec.alu_op    = c_alu_add;
          w_dec.use_imm   = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        c_op_lw: begin
          w_dec.alu_op    = c_alu_add;
          w_dec.use_imm   = 1'b1;
          w_dec.mem_read  = 1'b1;
          w_dec.reg_write = 1'b1;
        end
        c_op_sw: begin
          w_dec.alu_op    = c_alu_add;
          w_dec.use_imm   = 1'b1;
          w_dec.mem_write = 1'b1;
        end
        c_op_beq, c_op_bgt, c_op_bge: begin
          w_dec.alu_op    = c_alu_sub;
          w_dec.branch    = 1'b1;
          w_dec.br_cond   = 2'(w_opcode - c_op_beq);
        end
        default: begin
          w_dec.illegal   = 1'b1;
        end
      endcase
    end
  end

  // Main/skid storage: flush wins, then skid drain, then normal accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_consume) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || out_ready_i) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end else if (w_consume) begin
      r_main_valid <= 1'b0;
    end
  end

  // Saturating count of illegal words that survive their arrival cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_illegal_cnt <= 8'd0;
    end else if (w_accept && !flush_i && w_dec.illegal && r_illegal_cnt != c_cnt_max) begin
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

  // Ready depends only on stored state, never on out_ready_i
  assign in_ready_o    = ~r_skid_valid;
  assign out_valid_o   = r_main_valid;
  assign ra_o          = r_main.ra;
  assign rb_o          = r_main.rb;
  assign rd_o          = r_main.rd;
  assign imm_o         = r_main.imm;
  assign alu_op_o      = r_main.alu_op;
  assign use_imm_o     = r_main.use_imm;
  assign reg_write_o   = r_main.reg_write;
  assign mem_read_o    = r_main.mem_read;
  assign mem_write_o   = r_main.mem_write;
  assign branch_o      = r_main.branch;
  assign br_cond_o     = r_main.br_cond;
  assign illegal_o     = r_main.illegal;
  assign illegal_cnt_o = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode
// Description : Self-checking bench for instr_decode; decoded bundles are
//               predicted by an independent model and queued in a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  ra_o, rb_o, rd_o;
  logic [31:0] imm_o;
  logic [2:0]  alu_op_o;
  logic        use_imm_o, reg_write_o, mem_read_o, mem_write_o, branch_o;
  logic [1:0]  br_cond_o;
  logic        illegal_o;
  logic [7:0]  illegal_cnt_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [57:0] sb[$];
  int          exp_cnt = 0;
  logic [57:0] got_bundle;

  instr_decode #(.DATAWIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .ra_o(ra_o), .rb_o(rb_o), .rd_o(rd_o), .imm_o(imm_o),
    .alu_op_o(alu_op_o), .use_imm_o(use_imm_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .br_cond_o(br_cond_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign got_bundle = {ra_o, rb_o, rd_o, imm_o, alu_op_o, use_imm_o, reg_write_o,
                       mem_read_o, mem_write_o, branch_o, br_cond_o, illegal_o};

  // Reference decode: {ra,rb,rd,imm,alu_op,use_imm,reg_write,mem_read,mem_write,branch,br_cond,illegal}
  function automatic logic [57:0] model(input logic [31:0] w);
    logic [2:0] alu;
    logic       ui, rw, mr, mw, br, il;
    logic [1:0] bc;
    alu = 3'd0; ui = 0; rw = 0; mr = 0; mw = 0; br = 0; il = 0; bc = 2'd0;
    case (w[3:0])
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin alu = w[2:0]; rw = 1; end
      4'd7:  begin ui = 1; rw = 1; end
      4'd8:  begin ui = 1; rw = 1; mr = 1; end
      4'd9:  begin ui = 1; mw = 1; end
      4'd10: begin alu = 3'd1; br = 1; bc = 2'd0; end
      4'd11: begin alu = 3'd1; br = 1; bc = 2'd1; end
      4'd12: begin alu = 3'd1; br = 1; bc = 2'd2; end
      default: il = 1;
    endcase
    return {w[18:14], w[13:9], w[8:4], {{19{w[31]}}, w[31:19]}, alu, ui, rw, mr, mw, br, bc, il};
  endfunction

  function automatic logic [31:0] mk(input logic [12:0] off, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [4:0] rd,
                                     input logic [3:0] op);
    return {off, ra, rb, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the scoreboard, then advance the model
  task automatic cycle(output bit acc);
    bit a, cons;
    chk("out_valid", 64'(out_valid_o), 64'(sb.size() > 0));
    chk("in_ready", 64'(in_ready_o), 64'(sb.size() < 2));
    chk("illegal_cnt", 64'(illegal_cnt_o), 64'(exp_cnt));
    if (out_valid_o && sb.size() > 0) chk("bundle", 64'(got_bundle), 64'(sb[0]));
    a    = in_valid_i & in_ready_o;
    cons = out_valid_o & out_ready_i;
    @(posedge clk_i);
    if (flush_i) begin
      sb.delete();
    end else begin
      if (cons && sb.size() > 0) void'(sb.pop_front());
      if (a) begin
        sb.push_back(model(instr_i));
        if (instr_i[3:0] >= 4'd13 && exp_cnt < 255) exp_cnt++;
      end
    end
    acc = a & ~flush_i;
    @(negedge clk_i);
  endtask

  task automatic send(input logic [31:0] w);
    bit acc;
    in_valid_i = 1'b1; instr_i = w;
    cycle(acc);
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    bit acc;
    bit done;
    rst_i = 1'b1; in_valid_i = 1'b0; instr_i = 32'd0; flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    // Reset state
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_cnt", 64'(illegal_cnt_o), 64'd0);
    chk("rst_bundle", 64'(got_bundle), 64'd0);
    rst_i = 1'b0;
    idle(1);

    // ADD stream and the rest of the ALU ops back-to-back
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; instr_i = 32'h0000_4230;
    cycle(acc);
    chk("add_ra", 64'(ra_o), 64'd1);
    chk("add_rd", 64'(rd_o), 64'd3);
    chk("add_reg_write", 64'(reg_write_o), 64'd1);
    for (int op = 1; op <= 6; op++) begin
      instr_i = mk(13'(op * 97), 5'(op), 5'(op + 7), 5'(31 - op), 4'(op));
      cycle(acc);
      chk("stream_valid", 64'(out_valid_o), 64'd1);
    end
    in_valid_i = 1'b0;
    idle(2);

    // ADDI with positive and all-ones offsets
    send(mk(13'd69, 5'd0, 5'd0, 5'd1, 4'd7));
    chk("addi_imm", 64'(imm_o), 64'd69);
    chk("addi_use_imm", 64'(use_imm_o), 64'd1);
    send(mk(13'h1FFF, 5'd2, 5'd3, 5'd4, 4'd7));
    chk("addi_imm_neg", 64'(imm_o), 64'hFFFF_FFFF);
    idle(2);

    // Back-pressure: LW in main, SW in skid, BEQ held off
    out_ready_i = 1'b0;
    send(mk(13'd16, 5'd5, 5'd6, 5'd0, 4'd8));
    send(mk(13'h1FF0, 5'd7, 5'd8, 5'd0, 4'd9));
    in_valid_i = 1'b1; instr_i = mk(13'd12, 5'd9, 5'd10, 5'd0, 4'd10);
    cycle(acc);
    chk("bp_beq_held", 64'(acc), 64'd0);
    chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    idle(2);
    out_ready_i = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle(acc);
      done = acc;
    end
    chk("bp_beq_accept", 64'(done), 64'd1);
    in_valid_i = 1'b0;
    chk("beq_branch", 64'(branch_o), 64'd1);
    chk("beq_cond", 64'(br_cond_o), 64'd0);
    idle(3);

    // Flush with both entries full and BGE arriving
    out_ready_i = 1'b0;
    send(mk(13'd1, 5'd1, 5'd2, 5'd3, 4'd0));
    send(mk(13'd2, 5'd4, 5'd5, 5'd6, 4'd1));
    in_valid_i = 1'b1; flush_i = 1'b1; instr_i = mk(13'd3, 5'd7, 5'd8, 5'd9, 4'd12);
    cycle(acc);
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    idle(3);

    // Illegal words: a few counted, one flushed on arrival, then saturation
    for (int i = 0; i < 3; i++) send(mk(13'(i), 5'(i), 5'd1, 5'd2, 4'd15));
    in_valid_i = 1'b1; flush_i = 1'b1; instr_i = mk(13'd0, 5'd0, 5'd0, 5'd0, 4'd13);
    cycle(acc);
    in_valid_i = 1'b0; flush_i = 1'b0;
    chk("ill_flushed_cnt", 64'(illegal_cnt_o), 64'd3);
    in_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      instr_i = {$urandom_range(8191, 0) > 0 ? 13'($urandom) : 13'd0, 5'($urandom), 5'($urandom), 5'($urandom), 4'd15};
      cycle(acc);
    end
    in_valid_i = 1'b0;
    chk("ill_flag", 64'(illegal_o), 64'd1);
    chk("ill_no_strobes", 64'({reg_write_o, use_imm_o, mem_read_o, mem_write_o, branch_o, alu_op_o}), 64'd0);
    idle(1);
    chk("ill_saturated", 64'(illegal_cnt_o), 64'd255);

    // Asynchronous reset between edges with both entries full
    out_ready_i = 1'b0;
    send(mk(13'd5, 5'd1, 5'd1, 5'd1, 4'd2));
    send(mk(13'd6, 5'd2, 5'd2, 5'd2, 4'd3));
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_in_ready", 64'(in_ready_o), 64'd1);
    chk("arst_cnt", 64'(illegal_cnt_o), 64'd0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    send(mk(13'd7, 5'd3, 5'd4, 5'd5, 4'd11));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
